ifetch_unit: RTL and testbench

Instruction-fetch stage sitting directly upstream of the processor core. It takes the core's `pcaddr`, returns the instruction word, and drives the core's `en` low while a miss is serviced. It holds a one-line instruction buffer and talks to external instruction memory over a variable-latency req/ack handshake. It also keeps a saturating miss-stall counter for bring-up.

---
 rtl/ifetch_pkg.sv | 7 +
 rtl/ifetch_line.sv | 35 +++
 rtl/ifetch_unit.sv | 137 +++++++++++++
 tb/tb_ifetch_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared state type and constants for the instruction-fetch stage
package ifetch_pkg;
    localparam int          IFETCH_ADDR_W = 16;
    localparam int          IFETCH_DATA_W = 16;
    localparam logic [15:0] MISS_CNT_MAX  = 16'hFFFF;
    typedef enum logic [1:0] {IDLE, DEMAND, PREFETCH} ifetch_state_t;
endpackage

// File: rtl/ifetch_line.sv
// ifetch_line: one tag/valid/data buffer line with load, invalidate and address compare
module ifetch_line
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = IFETCH_ADDR_W,
    parameter int DATA_W = IFETCH_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inval,
    input  logic [ADDR_W-1:0] ld_tag,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);
    logic              valid;
    logic [ADDR_W-1:0] tag;
    // Load takes priority over invalidate; reset leaves the line empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            tag   <= ld_tag;
            data  <= ld_data;
        end else if (inval) begin
            valid <= 1'b0;
        end
    end
    assign hit = valid && (tag == addr);
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: one-line instruction buffer refilled over req/ack, with a saturating stall counter.
// Defining IFETCH_PREFETCH_EN adds a next-address prefetch line and the PREFETCH state.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = IFETCH_ADDR_W,
    parameter int DATA_W = IFETCH_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pcaddr,
    output logic [DATA_W-1:0] instruction,
    output logic              en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [15:0]       miss_cycles
);
    ifetch_state_t     state, state_nx;
    logic [ADDR_W-1:0] addr_nx, d_ld_tag;
    logic [DATA_W-1:0] d_ld_data, d_data;
    logic              d_load, d_hit;

    ifetch_line #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dline (
        .clk     (clk),
        .rst     (rst),
        .load    (d_load),
        .inval   (1'b0),
        .ld_tag  (d_ld_tag),
        .ld_data (d_ld_data),
        .addr    (pcaddr),
        .hit     (d_hit),
        .data    (d_data)
    );

`ifdef IFETCH_PREFETCH_EN
    logic [DATA_W-1:0] p_data;
    logic              p_load, p_inval, p_hit, pf_due;

    ifetch_line #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pline (
        .clk     (clk),
        .rst     (rst),
        .load    (p_load),
        .inval   (p_inval),
        .ld_tag  (imem_addr),
        .ld_data (imem_rdata),
        .addr    (pcaddr),
        .hit     (p_hit),
        .data    (p_data)
    );

    assign en          = d_hit || p_hit;
    assign instruction = p_hit ? p_data : d_data;

    // Marks a freshly filled demand line whose successor has not been requested yet
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pf_due <= 1'b0;
        else if (state_nx == PREFETCH)
            pf_due <= 1'b0;
        else if (d_load)
            pf_due <= 1'b1;
    end
`else
    assign en          = d_hit;
    assign instruction = d_data;
`endif

    assign imem_req = (state != IDLE);

    // Next state and line loads; imem_addr only moves when a request starts
    always_comb begin
        state_nx  = state;
        addr_nx   = imem_addr;
        d_load    = 1'b0;
        d_ld_tag  = imem_addr;
        d_ld_data = imem_rdata;
`ifdef IFETCH_PREFETCH_EN
        p_load    = 1'b0;
        p_inval   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!en) begin
                    addr_nx  = pcaddr;
                    state_nx = DEMAND;
                end
`ifdef IFETCH_PREFETCH_EN
                else if (p_hit) begin
                    d_load    = 1'b1;
                    d_ld_tag  = pcaddr;
                    d_ld_data = p_data;
                    p_inval   = 1'b1;
                    addr_nx   = pcaddr + 1'b1;
                    state_nx  = PREFETCH;
                end else if (pf_due) begin
                    addr_nx  = pcaddr + 1'b1;
                    state_nx = PREFETCH;
                end
`endif
            end
            DEMAND: begin
                if (imem_ack) begin
                    d_load   = 1'b1;
                    state_nx = IDLE;
                end
            end
`ifdef IFETCH_PREFETCH_EN
            PREFETCH: begin
                if (imem_ack) begin
                    state_nx = IDLE;
                    if (!en && pcaddr == imem_addr)
                        d_load = 1'b1;
                    else
                        p_load = 1'b1;
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    // State, request address and saturating stall counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            imem_addr   <= '0;
            miss_cycles <= '0;
        end else begin
            state     <= state_nx;
            imem_addr <= addr_nx;
            if (!en && miss_cycles != MISS_CNT_MAX)
                miss_cycles <= miss_cycles + 1'b1;
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: randomized fetch sequences checked against a transaction-level buffer model
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pcaddr = 16'h0010;
    logic [15:0] instruction;
    logic        en;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [15:0] miss_cycles;

    int          n_err = 0;
    int          n_checks = 0;
    bit          m_valid = 0;
    logic [15:0] m_tag = '0;
    logic [15:0] m_data = '0;
    int          miss_exp = 0;
    logic [15:0] last_pc = '0;
    bit          last_stall = 0;

    ifetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pcaddr      (pcaddr),
        .instruction (instruction),
        .en          (en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .miss_cycles (miss_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Core keeps pcaddr frozen across consecutive stalled cycles
    always @(negedge clk) begin
        if (last_stall && rst && !en && pcaddr != last_pc)
            check("pc_stable", {16'h0, pcaddr}, {16'h0, last_pc});
        last_pc    = pcaddr;
        last_stall = rst && !en;
    end

    // n hit cycles with ack noise while req is low
    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = 16'($urandom);
            #1;
            check("hit_en", en, 1);
            check("hit_ins", instruction, m_data);
            check("hit_req", imem_req, 0);
            step();
        end
        imem_ack = 1'b0;
        #1;
        check("hit_miss_cnt", miss_cycles, sat(miss_exp));
    endtask

    // Present address a; on a miss memory answers after lat extra req cycles with d
    task automatic fetch(input logic [15:0] a, input int lat, input logic [15:0] d);
        pcaddr = a;
        if (m_valid && m_tag == a) begin
            hold(1);
            return;
        end
        imem_ack   = 1'b1;
        imem_rdata = 16'($urandom);
        #1;
        check("det_en", en, 0);
        check("det_req", imem_req, 0);
        step();
        for (int i = 0; i <= lat; i++) begin
            imem_ack   = (i == lat);
            imem_rdata = (i == lat) ? d : 16'($urandom);
            #1;
            check("req", imem_req, 1);
            check("req_addr", imem_addr, a);
            check("stall_en", en, 0);
            step();
        end
        imem_ack = 1'b0;
        m_valid  = 1;
        m_tag    = a;
        m_data   = d;
        miss_exp = sat(miss_exp + lat + 2);
        #1;
        check("fill_en", en, 1);
        check("fill_ins", instruction, d);
        check("fill_req", imem_req, 0);
        check("fill_miss_cnt", miss_cycles, miss_exp);
        hold(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        #3;
        check("rst_en", en, 0);
        check("rst_ins", instruction, 0);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_miss", miss_cycles, 0);
        step();
        rst = 1'b1;
        fetch(16'h0010, 0, 16'hA5C3);
        hold(5);
        fetch(16'h0011, 3, 16'h1234);
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0:       a = m_tag;
                1:       a = m_tag + 16'h1;
                default: a = 16'($urandom_range(0, 15));
            endcase
            fetch(a, $urandom_range(0, 4), 16'($urandom));
            hold($urandom_range(0, 2));
        end
        a = (m_valid && m_tag == 16'h0042) ? 16'h0043 : 16'h0042;
        pcaddr   = a;
        imem_ack = 1'b0;
        step();
        step();
        check("mid_req", imem_req, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_req", imem_req, 0);
        check("arst_en", en, 0);
        check("arst_ins", instruction, 0);
        check("arst_miss", miss_cycles, 0);
        imem_ack   = 1'b1;
        imem_rdata = 16'hDEAD;
        step();
        rst      = 1'b1;
        m_valid  = 0;
        miss_exp = 0;
        fetch(a, 1, 16'h0F0F);
        rst = 1'b0;
        pcaddr   = 16'h0100;
        imem_ack = 1'b0;
        step();
        rst = 1'b1;
        m_valid  = 0;
        step();
        for (int i = 0; i < 70000; i++)
            step();
        check("sat_miss", miss_cycles, 16'hFFFF);
        step();
        step();
        check("sat_hold", miss_cycles, 16'hFFFF);
        check("sat_req", imem_req, 1);
        check("sat_addr", imem_addr, 16'h0100);
        imem_ack   = 1'b1;
        imem_rdata = 16'h7E57;
        step();
        imem_ack = 1'b0;
        m_valid  = 1;
        m_tag    = 16'h0100;
        m_data   = 16'h7E57;
        miss_exp = 65535;
        #1;
        check("sat_fill_en", en, 1);
        check("sat_fill_ins", instruction, 16'h7E57);
        hold(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
